// File: rtl/sd_write_data_transmitter.sv
// SPI-mode SD single-block write data phase: gap, start token, 4096 data bits, CRC16, data response, busy wait.
// Optional macro SD_WRITE_CRC16_EN: send a real CRC16-CCITT over the payload instead of 16'hFFFF.
module sd_write_data_transmitter #(
    parameter int GAP_BITS     = 8,
    parameter int RESP_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT = 1048576
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [4095:0] WRITE_DATA,
    input  logic          DO,
    output logic          DI,
    output logic          BUSY,
    output logic          FINISH,
    output logic [2:0]    STATUS,
    output logic          ERROR
);
    typedef enum logic [3:0] {
        IDLE, GAP, TOKEN, DATA, CRC, RESP_WAIT, RESP, BUSY_WAIT, DONE
    } state_t;

    localparam logic [7:0]  START_TOKEN = 8'hFE;
    localparam logic [12:0] GAP_LAST    = 13'(GAP_BITS - 1);
    localparam logic [20:0] RESP_LAST   = 21'(RESP_TIMEOUT - 1);
    localparam logic [20:0] BUSY_LAST   = 21'(BUSY_TIMEOUT - 1);

    state_t        state;
    logic [12:0]   bit_cnt;
    logic [4095:0] shift;
    logic [20:0]   tmo_cnt;
    logic          resp_bad;

`ifdef SD_WRITE_CRC16_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // DI always carries the bit for the cycle that starts at this edge, so
    // every branch decides what the line shows next, not what it shows now.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            // NOTE: the wide shift register is cleared on reset so a stale
            // payload can never leak onto DI after an abandoned transfer.
            shift    <= '0;
            tmo_cnt  <= '0;
            resp_bad <= 1'b0;
            DI       <= 1'b1;
            BUSY     <= 1'b0;
            FINISH   <= 1'b0;
            STATUS   <= 3'b000;
            ERROR    <= 1'b0;
`ifdef SD_WRITE_CRC16_EN
            crc      <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the register values from before this edge.
            case (state)
                IDLE: begin
                    DI     <= 1'b1;
                    FINISH <= 1'b0;
                    if (START) begin
                        shift   <= WRITE_DATA;
                        STATUS  <= 3'b000;
                        ERROR   <= 1'b0;
                        BUSY    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= GAP;
`ifdef SD_WRITE_CRC16_EN
                        crc     <= '0;
`endif
                    end
                end
                GAP: begin
                    if (bit_cnt == GAP_LAST) begin
                        bit_cnt <= '0;
                        DI      <= START_TOKEN[7];
                        state   <= TOKEN;
                    end else begin
                        bit_cnt <= bit_cnt + 13'd1;
                        DI      <= 1'b1;
                    end
                end
                TOKEN: begin
                    if (bit_cnt == 13'd7) begin
                        bit_cnt <= '0;
                        DI      <= shift[4095];
                        shift   <= {shift[4094:0], 1'b0};
                        state   <= DATA;
`ifdef SD_WRITE_CRC16_EN
                        crc     <= crc_step(crc, shift[4095]);
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 13'd1;
                        DI      <= START_TOKEN[3'd6 - bit_cnt[2:0]];
                    end
                end
                DATA: begin
                    if (bit_cnt == 13'd4095) begin
                        bit_cnt <= '0;
                        state   <= CRC;
`ifdef SD_WRITE_CRC16_EN
                        DI      <= crc[15];
                        crc     <= {crc[14:0], 1'b0};
`else
                        DI      <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 13'd1;
                        DI      <= shift[4095];
                        shift   <= {shift[4094:0], 1'b0};
`ifdef SD_WRITE_CRC16_EN
                        crc     <= crc_step(crc, shift[4095]);
`endif
                    end
                end
                CRC: begin
                    if (bit_cnt == 13'd15) begin
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        DI      <= 1'b1;
                        state   <= RESP_WAIT;
                    end else begin
                        bit_cnt <= bit_cnt + 13'd1;
`ifdef SD_WRITE_CRC16_EN
                        DI      <= crc[15];
                        crc     <= {crc[14:0], 1'b0};
`else
                        DI      <= 1'b1;
`endif
                    end
                end
                RESP_WAIT: begin
                    DI <= 1'b1;
                    if (!DO) begin
                        bit_cnt <= '0;
                        state   <= RESP;
                    end else if (tmo_cnt == RESP_LAST) begin
                        STATUS <= 3'b111;
                        ERROR  <= 1'b1;
                        FINISH <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 21'd1;
                    end
                end
                RESP: begin
                    DI <= 1'b1;
                    if (bit_cnt == 13'd3) begin
                        // Fourth bit is the token's end bit; a good response is 0_010_1.
                        resp_bad <= (STATUS != 3'b010) || !DO;
                        tmo_cnt  <= '0;
                        state    <= BUSY_WAIT;
                    end else begin
                        STATUS  <= {STATUS[1:0], DO};
                        bit_cnt <= bit_cnt + 13'd1;
                    end
                end
                BUSY_WAIT: begin
                    DI <= 1'b1;
                    if (DO) begin
                        ERROR  <= resp_bad;
                        FINISH <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= DONE;
                    end else if (tmo_cnt == BUSY_LAST) begin
                        ERROR  <= 1'b1;
                        FINISH <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 21'd1;
                    end
                end
                DONE: begin
                    DI     <= 1'b1;
                    FINISH <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    DI    <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
